// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter (dmem_arbiter).
package dmem_arb_pkg;

    typedef enum logic {
        PIPE_PRI  = 1'b0,
        CAM_BURST = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_CAM  = 2'd2
    } grant_t;

    localparam int DEF_MAX_WAIT  = 8;
    localparam int DEF_BURST_LEN = 4;
    localparam int STAT_W        = 16;

endpackage

// File: rtl/dmem_arb_stats.sv
// Saturating stall / camera-grant counters for dmem_arbiter.
// Compiled only when DMEM_ARB_STATS_EN is defined; otherwise no counter flops exist.
`ifdef DMEM_ARB_STATS_EN
module dmem_arb_stats
    import dmem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall_i,
    input  logic              cam_gnt_i,
    output logic [STAT_W-1:0] stall_cnt_o,
    output logic [STAT_W-1:0] cam_cnt_o
);

    localparam logic [STAT_W-1:0] CNT_MAX = '1;

    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [STAT_W-1:0] cam_cnt_q, cam_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        cam_cnt_d   = cam_cnt_q;
        if (stall_i && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + STAT_W'(1);
        end
        if (cam_gnt_i && (cam_cnt_q != CNT_MAX)) begin
            cam_cnt_d = cam_cnt_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            cam_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            cam_cnt_q   <= cam_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign cam_cnt_o   = cam_cnt_q;

endmodule
`endif

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: pipeline MEM stage has priority, camera gets a bounded
// forced burst after MAX_WAIT denied cycles. Optional statistics under DMEM_ARB_STATS_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int MAX_WAIT  = DEF_MAX_WAIT,
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pipe_req,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic              stall_m,
    output logic [DATA_W-1:0] pipe_rdata,
    output logic              pipe_rvalid,
    input  logic              cam_valid,
    input  logic [ADDR_W-1:0] cam_addr,
    input  logic [DATA_W-1:0] cam_wdata,
    output logic              cam_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       stat_stall_cnt,
    output logic [15:0]       stat_cam_cnt
);

    localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam int BURST_W = $clog2(BURST_LEN + 1);
    localparam logic [WAIT_W-1:0]  WAIT_LIMIT = WAIT_W'(MAX_WAIT);
    localparam logic [BURST_W-1:0] BURST_LOAD = BURST_W'(BURST_LEN);

    arb_state_t         state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic               pipe_rvalid_q, pipe_rvalid_d;
    grant_t             gnt;

    always_comb begin
        gnt = GNT_NONE;
        if (state_q == CAM_BURST) begin
            if (cam_valid)     gnt = GNT_CAM;
            else if (pipe_req) gnt = GNT_PIPE;
        end else begin
            if (pipe_req)       gnt = GNT_PIPE;
            else if (cam_valid) gnt = GNT_CAM;
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (gnt)
            GNT_PIPE: begin
                mem_en    = 1'b1;
                mem_we    = pipe_we;
                mem_addr  = pipe_addr;
                mem_wdata = pipe_wdata;
            end
            GNT_CAM: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cam_addr;
                mem_wdata = cam_wdata;
            end
            default: ;
        endcase
    end

    assign cam_ready   = (gnt == GNT_CAM);
    assign stall_m     = pipe_req && (gnt != GNT_PIPE);
    assign pipe_rdata  = mem_rdata;
    assign pipe_rvalid = pipe_rvalid_q;

    always_comb begin
        state_d       = state_q;
        burst_cnt_d   = burst_cnt_q;
        pipe_rvalid_d = (gnt == GNT_PIPE) && !pipe_we;
        if (cam_valid && !cam_ready) begin
            wait_cnt_d = (wait_cnt_q == WAIT_LIMIT) ? WAIT_LIMIT : wait_cnt_q + WAIT_W'(1);
        end else begin
            wait_cnt_d = '0;
        end
        case (state_q)
            PIPE_PRI: begin
                // The pipeline still wins the cycle the limit is hit; the burst starts next cycle.
                if (wait_cnt_d == WAIT_LIMIT) begin
                    state_d     = CAM_BURST;
                    burst_cnt_d = BURST_LOAD;
                end
            end
            CAM_BURST: begin
                if (!cam_valid) begin
                    state_d     = PIPE_PRI;
                    burst_cnt_d = '0;
                    wait_cnt_d  = '0;
                end else begin
                    burst_cnt_d = burst_cnt_q - BURST_W'(1);
                    if (burst_cnt_q == BURST_W'(1)) begin
                        state_d    = PIPE_PRI;
                        wait_cnt_d = '0;
                    end
                end
            end
            default: state_d = PIPE_PRI;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= PIPE_PRI;
            wait_cnt_q    <= '0;
            burst_cnt_q   <= '0;
            pipe_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            burst_cnt_q   <= burst_cnt_d;
            pipe_rvalid_q <= pipe_rvalid_d;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    dmem_arb_stats u_stats (
        .clk         (clk),
        .reset_n     (reset_n),
        .stall_i     (stall_m),
        .cam_gnt_i   (cam_ready),
        .stall_cnt_o (stat_stall_cnt),
        .cam_cnt_o   (stat_cam_cnt)
    );
`else
    assign stat_stall_cnt = '0;
    assign stat_cam_cnt   = '0;
`endif

endmodule
